// File: rtl/button_pkg.sv
// Shared definitions for the button event classifier.
// State encoding, default timing constants and a small state helper.
package button_pkg;

  localparam int unsigned LONG_CYCLES_DEF   = 1000;
  localparam int unsigned GAP_CYCLES_DEF    = 250;
  localparam int unsigned REPEAT_CYCLES_DEF = 100;
  localparam int unsigned CNT_W_DEF         = 16;

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] IDLE      = 3'd0;
  localparam logic [STATE_W-1:0] PRESSED   = 3'd1;
  localparam logic [STATE_W-1:0] LONG_HELD = 3'd2;
  localparam logic [STATE_W-1:0] WAIT_GAP  = 3'd3;
  localparam logic [STATE_W-1:0] SECOND    = 3'd4;

  // True for every state in which the button is considered down.
  function automatic logic is_down(input logic [STATE_W-1:0] st);
    logic r;
    case (st)
      PRESSED, LONG_HELD, SECOND: r = 1'b1;
      default:                    r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/button_edge.sv
// Edge detector for the active-low debounced button level.
// The history register resets to "released", so a button already held
// when reset deasserts is reported as a fresh press.
module button_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n_i,
  output logic press_o,
  output logic release_o
);

  logic btn_q;

  // One-cycle history of the button level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_q <= 1'b1;
    end else begin
      btn_q <= btn_n_i;
    end
  end

  assign press_o   = btn_q & ~btn_n_i;
  assign release_o = ~btn_q & btn_n_i;

endmodule

// File: rtl/button_event.sv
// Button event classifier: turns the debounced level into one-cycle
// press / release / short-click / double-click / long-press pulses.
// Optional auto-repeat during a long hold is enabled by defining the
// macro BUTTON_EVENT_REPEAT_EN; otherwise repeat_pulse stays 0.
module button_event
  import button_pkg::*;
#(
  parameter int unsigned LONG_CYCLES   = LONG_CYCLES_DEF,
  parameter int unsigned GAP_CYCLES    = GAP_CYCLES_DEF,
  parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_DEF,
  parameter int unsigned CNT_W         = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_click,
  output logic double_click,
  output logic long_press,
  output logic repeat_pulse,
  output logic held
);

`ifdef BUTTON_EVENT_REPEAT_EN
  localparam logic REPEAT_ON = 1'b1;
`else
  localparam logic REPEAT_ON = 1'b0;
`endif

  // Thresholds are compared against the timer value seen in the last cycle
  // of the interval, hence the "- 1".
  localparam logic [CNT_W-1:0] LONG_T = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_T  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_T  = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] T_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] T_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] T_ZERO = {CNT_W{1'b0}};

  logic               press_s;
  logic               release_s;
  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]   t_q, t_d;
  logic               t_clr;
  logic               long_hit;
  logic               gap_hit;
  logic               rep_hit;

  logic press_d, release_d, short_d, double_d, long_d, repeat_d, held_d;
  logic press_q, release_q, short_q, double_q, long_q, repeat_q, held_q;

  button_edge u_edge (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_n_i   (btn_n),
    .press_o   (press_s),
    .release_o (release_s)
  );

  assign long_hit = (t_q == LONG_T);
  assign gap_hit  = (t_q == GAP_T);
  assign rep_hit  = REPEAT_ON & (t_q == REP_T);

  // State and timer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      t_q     <= T_ZERO;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
    end
  end

  // Next-state logic; edges take priority over timer thresholds.
  always_comb begin
    state_d = state_q;
    t_clr   = 1'b0;
    case (state_q)
      IDLE: begin
        if (press_s) begin
          state_d = PRESSED;
          t_clr   = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      PRESSED: begin
        if (release_s) begin
          state_d = WAIT_GAP;
          t_clr   = 1'b1;
        end else if (long_hit) begin
          state_d = LONG_HELD;
          t_clr   = 1'b1;
        end else begin
          state_d = PRESSED;
        end
      end
      LONG_HELD: begin
        if (release_s) begin
          state_d = IDLE;
          t_clr   = 1'b1;
        end else if (rep_hit) begin
          state_d = LONG_HELD;   // timer reloads at each repeat
          t_clr   = 1'b1;
        end else begin
          state_d = LONG_HELD;
        end
      end
      WAIT_GAP: begin
        if (press_s) begin
          state_d = SECOND;
          t_clr   = 1'b1;
        end else if (gap_hit) begin
          state_d = IDLE;
          t_clr   = 1'b1;
        end else begin
          state_d = WAIT_GAP;
        end
      end
      SECOND: begin
        if (release_s) begin
          state_d = IDLE;
          t_clr   = 1'b1;
        end else if (long_hit) begin
          state_d = LONG_HELD;
          t_clr   = 1'b1;
        end else begin
          state_d = SECOND;
        end
      end
      default: begin
        state_d = IDLE;
        t_clr   = 1'b1;
      end
    endcase
  end

  // Timer: cleared on state entry, otherwise saturating increment.
  always_comb begin
    if (t_clr) begin
      t_d = T_ZERO;
    end else if (t_q == T_MAX) begin
      t_d = t_q;
    end else begin
      t_d = t_q + T_ONE;
    end
  end

  // Next values of the registered event outputs.
  always_comb begin
    press_d   = 1'b0;
    release_d = 1'b0;
    short_d   = 1'b0;
    double_d  = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    held_d    = is_down(state_d);
    case (state_q)
      IDLE: begin
        press_d = press_s;
      end
      PRESSED: begin
        if (release_s) begin
          release_d = 1'b1;
        end else if (long_hit) begin
          long_d = 1'b1;
        end else begin
          long_d = 1'b0;
        end
      end
      LONG_HELD: begin
        if (release_s) begin
          release_d = 1'b1;
        end else if (rep_hit) begin
          repeat_d = 1'b1;
        end else begin
          repeat_d = 1'b0;
        end
      end
      WAIT_GAP: begin
        if (press_s) begin
          press_d = 1'b1;
        end else if (gap_hit) begin
          short_d = 1'b1;
        end else begin
          short_d = 1'b0;
        end
      end
      SECOND: begin
        if (release_s) begin
          release_d = 1'b1;
          double_d  = 1'b1;
        end else if (long_hit) begin
          long_d = 1'b1;
        end else begin
          long_d = 1'b0;
        end
      end
      default: begin
        press_d = 1'b0;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      short_q   <= 1'b0;
      double_q  <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      press_q   <= press_d;
      release_q <= release_d;
      short_q   <= short_d;
      double_q  <= double_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      held_q    <= held_d;
    end
  end

  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign short_click   = short_q;
  assign double_click  = double_q;
  assign long_press    = long_q;
  assign repeat_pulse  = repeat_q;
  assign held          = held_q;

endmodule

// File: tb/tb_button_event.sv
// Directed testbench for button_event (LONG=16, GAP=8, REPEAT=4).
module tb_button_event;

  logic clk;
  logic rst_n;
  logic btn_n;
  logic press_pulse, release_pulse, short_click, double_click;
  logic long_press, repeat_pulse, held;

  int n_checks;
  int n_fail;
  int cyc;

  // Event counters (monotonic) and last-seen cycle of each event.
  int c_press, c_rel, c_short, c_dbl, c_long, c_rep, c_held, c_excl;
  int t_press, t_rel, t_short, t_dbl, t_long, t_rep_first, t_rep_last;
  int b_press, b_rel, b_short, b_dbl, b_long, b_rep, b_held;
  int rst_rel_cyc;

  button_event #(
    .LONG_CYCLES   (16),
    .GAP_CYCLES    (8),
    .REPEAT_CYCLES (4),
    .CNT_W         (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_n         (btn_n),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .short_click   (short_click),
    .double_click  (double_click),
    .long_press    (long_press),
    .repeat_pulse  (repeat_pulse),
    .held          (held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Sample outputs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (press_pulse)   begin c_press = c_press + 1; t_press = cyc; end
    if (release_pulse) begin c_rel   = c_rel + 1;   t_rel   = cyc; end
    if (short_click)   begin c_short = c_short + 1; t_short = cyc; end
    if (double_click)  begin c_dbl   = c_dbl + 1;   t_dbl   = cyc; end
    if (long_press)    begin c_long  = c_long + 1;  t_long  = cyc; end
    if (repeat_pulse) begin
      c_rep = c_rep + 1;
      if (c_rep - b_rep == 1) t_rep_first = cyc;
      t_rep_last = cyc;
    end
    if (held) c_held = c_held + 1;
    if (int'(short_click) + int'(double_click) + int'(long_press) > 1) c_excl = c_excl + 1;
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_press = c_press; b_rel = c_rel; b_short = c_short; b_dbl = c_dbl;
    b_long = c_long; b_rep = c_rep; b_held = c_held;
  endtask

  // Drive level b for n active edges; returns #1 after the last edge.
  task automatic step(input logic b, input int n);
    for (int i = 0; i < n; i++) begin
      btn_n = b;
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int outs_word();
    return int'({press_pulse, release_pulse, short_click, double_click,
                 long_press, repeat_pulse, held});
  endfunction

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0;
    c_press = 0; c_rel = 0; c_short = 0; c_dbl = 0; c_long = 0; c_rep = 0;
    c_held = 0; c_excl = 0;
    t_press = 0; t_rel = 0; t_short = 0; t_dbl = 0; t_long = 0;
    t_rep_first = 0; t_rep_last = 0;
    b_press = 0; b_rel = 0; b_short = 0; b_dbl = 0; b_long = 0; b_rep = 0; b_held = 0;
    rst_rel_cyc = 0;
    rst_n = 1'b0;
    btn_n = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_outputs", outs_word(), 0);
    rst_n = 1'b1;
    step(1'b1, 4);
    check_eq("idle_outputs", outs_word(), 0);

    // Single short click
    snap();
    step(1'b0, 5);
    step(1'b1, 12);
    check_eq("t1_press_cnt", c_press - b_press, 1);
    check_eq("t1_rel_cnt", c_rel - b_rel, 1);
    check_eq("t1_rel_after_press", t_rel - t_press, 5);
    check_eq("t1_short_cnt", c_short - b_short, 1);
    check_eq("t1_short_after_rel", t_short - t_rel, 8);
    check_eq("t1_double_cnt", c_dbl - b_dbl, 0);
    check_eq("t1_long_cnt", c_long - b_long, 0);

    // Double click
    snap();
    step(1'b0, 5);
    step(1'b1, 3);
    step(1'b0, 5);
    step(1'b1, 12);
    check_eq("t2_press_cnt", c_press - b_press, 2);
    check_eq("t2_rel_cnt", c_rel - b_rel, 2);
    check_eq("t2_double_cnt", c_dbl - b_dbl, 1);
    check_eq("t2_double_at_rel", t_dbl - t_rel, 0);
    check_eq("t2_short_cnt", c_short - b_short, 0);

    // Second press exactly at the last gap cycle still counts as double
    snap();
    step(1'b0, 5);
    step(1'b1, 8);
    step(1'b0, 3);
    step(1'b1, 12);
    check_eq("t2b_double_cnt", c_dbl - b_dbl, 1);
    check_eq("t2b_short_cnt", c_short - b_short, 0);

    // Long hold of 30 cycles
    snap();
    step(1'b0, 30);
    step(1'b1, 12);
    check_eq("t3_long_cnt", c_long - b_long, 1);
    check_eq("t3_long_after_press", t_long - t_press, 16);
    check_eq("t3_rel_cnt", c_rel - b_rel, 1);
    check_eq("t3_rel_after_press", t_rel - t_press, 30);
    check_eq("t3_short_cnt", c_short - b_short, 0);
    check_eq("t3_held_cycles", c_held - b_held, 30);
`ifdef BUTTON_EVENT_REPEAT_EN
    check_eq("t3_repeat_cnt", c_rep - b_rep, 3);
    check_eq("t3_repeat_first", t_rep_first - t_long, 4);
    check_eq("t3_repeat_last", t_rep_last - t_long, 12);
`else
    check_eq("t3_repeat_cnt", c_rep - b_rep, 0);
`endif

    // Release at the long threshold cycle counts as short
    snap();
    step(1'b0, 16);
    step(1'b1, 12);
    check_eq("t4_rel_after_press", t_rel - t_press, 16);
    check_eq("t4_long_cnt", c_long - b_long, 0);
    check_eq("t4_short_cnt", c_short - b_short, 1);
    check_eq("t4_short_after_rel", t_short - t_rel, 8);

    // Reset while waiting for the gap, button held through reset release
    snap();
    step(1'b0, 5);
    step(1'b1, 4);
    btn_n = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("t6_outputs_in_reset", outs_word(), 0);
    snap();
    step(1'b0, 6);
    check_eq("t6_events_in_reset",
             (c_press - b_press) + (c_rel - b_rel) + (c_short - b_short) +
             (c_dbl - b_dbl) + (c_long - b_long) + (c_rep - b_rep) + (c_held - b_held), 0);
    rst_n = 1'b1;
    rst_rel_cyc = cyc;
    snap();
    step(1'b0, 10);
    check_eq("t6_press_cnt", c_press - b_press, 1);
    check_eq("t6_press_latency", t_press - rst_rel_cyc, 1);
    check_eq("t6_short_cnt", c_short - b_short, 0);
    step(1'b1, 12);
    check_eq("t6_short_after", c_short - b_short, 1);

    check_eq("exclusive_events", c_excl, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
